draw_sprite_anim: RTL
=====================

Name: draw_sprite_anim

Overview:
Parametrised sprite overlay stage for the VGA pipeline. It draws an animated, horizontally mirrorable, colour-keyed sprite at a run-time position, using a synchronous image ROM that holds N_FRAMES frames stored back to back. Position and attributes are double-buffered per video frame, and the timing signals are delay-matched to the ROM latency. It sits in the vga_if chain after the background/terrain stage and is instantiated once per player.

Parameters:
SPRITE_W, 130, sprite width in pixels
SPRITE_H, 99, sprite height in pixels
N_FRAMES, 4, number of animation frames in ROM
FRAME_DIV, 8, video frames per animation step (>=1)
ROM_LAT, 1, ROM read latency in clk cycles (>=1)
ADDR_W, 16, ROM address width; elaboration error if N_FRAMES*SPRITE_W*SPRITE_H > 2**ADDR_W
KEY_COLOR, 12'h000, transparent colour

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
pos_x  in  11  sprite top-left x (requested)
pos_y  in  11  sprite top-left y (requested)
mirror  in  1  1 = draw horizontally flipped
visible  in  1  1 = draw sprite
anim_en  in  1  1 = cycle frames; 0 = idle pose (frame 0)
rom_addr  out  ADDR_W  ROM read address
rom_rgb  in  12  ROM data, valid ROM_LAT cycles after rom_addr
vga_in  vga_if.vga_in  upstream timing + rgb
vga_out  vga_if.vga_out  downstream timing + rgb

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Frame boundary (fb): cycle where vga_in.vblnk is 1 and was 0 the previous cycle (edge register).
- On fb: shadow regs take pos_x, pos_y, mirror, visible, anim_en. Inputs are not observed at any other time, so there is no mid-frame tearing.
- Animation: div_cnt counts fb events from 0 to FRAME_DIV-1. On wrap, frame_idx increments modulo N_FRAMES (N_FRAMES-1 -> 0). When the shadow anim_en is 0: div_cnt=0, frame_idx=0.
- Stage 1 (registered from vga_in):
  - hit = hc>=sx && hc<sx+SPRITE_W && vc>=sy && vc<sy+SPRITE_H && !hblnk && !vblnk && visible_s. Comparisons are 12-bit, so sx+SPRITE_W never wraps.
  - rel_x = hc-sx; rx = mirror_s ? SPRITE_W-1-rel_x : rel_x; ry = vc-sy.
  - rom_addr = frame_idx*SPRITE_W*SPRITE_H + ry*SPRITE_W + rx, computed at ADDR_W bits. Registered, so it appears 1 cycle after vga_in. When not hit, rom_addr holds 0.
- Delay: the timing bus (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) and hit are delayed ROM_LAT further cycles to align with rom_rgb.
- Output stage (registered): rgb = (hit_d && rom_rgb != KEY_COLOR) ? rom_rgb : rgb_d. Timing fields pass through.
- Total latency vga_in -> vga_out = ROM_LAT+2 cycles for all fields.
- Reset:
  - All vga_out fields and rom_addr are 0.
  - Shadow visible=0, pos=0, mirror=0; frame_idx=0, div_cnt=0.
  - Nothing is drawn until the first fb after reset, including when reset lands mid-frame.
- Partial off-screen (sx+SPRITE_W > hactive): only visible pixels are drawn; blanked pixels are never overwritten.
- Position change in the same cycle as fb: the new value is taken.

Optional Feature:
DRAW_SPRITE_BBOX_EN
- Defined: pixels on the 1-px border of the sprite rectangle (rel_x or ry equal to 0 or max) output 12'hF0F whenever visible_s=1, regardless of colour key. Debug use.
- Undefined: no border logic is generated; behaviour is exactly as above.

Decomposition:
- vga_pkg: add SPRITE_KEY_DEFAULT (12'h000) and BBOX_COLOR (12'hF0F). Timing constants stay in vga_pkg.
- One sub-module: delay_line (params WIDTH, DEPTH; synchronous reset to 0). It is used to delay the packed timing bus plus hit by ROM_LAT cycles.

Test Plan:
- Reset mid-frame, then pos=(100,200), visible=1: no sprite pixels before the next fb; after fb, pixel (100,200) maps to rom_addr 0 and pixel (229,298) maps to 12869.
- ROM_LAT=2, rom_rgb=12'h0F0 constant, vga_in.rgb=12'h00F: vga_out.rgb=0F0 exactly 4 cycles after hcount=100 enters, with 00F outside the sprite; hcount/hsync are aligned to the same 4-cycle delay.
- mirror=1 at pos (0,0): pixel (0,0) reads address 129; pixel (129,0) reads 0.
- rom_rgb=12'h000 inside the sprite: background 12'h00F passes through (key transparency).
- anim_en=1, FRAME_DIV=2, N_FRAMES=4: frame_idx goes 0,0,1,1,2,2,3,3,0 over 9 fb. The pixel (sx,sy) address on frame 1 is 12870. Dropping anim_en gives frame 0 at the next fb.
- pos_x written to 300 mid-frame: the current frame still draws at the old x; the change appears after fb. pos=(600,400) on a 640-wide display: only columns 600..639 are drawn, and blanking is untouched.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants, colour constants and the packed
//                timing-bus type used by the overlay stages.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    localparam logic [11:0] SPRITE_KEY_DEFAULT = 12'h000;
    localparam logic [11:0] BBOX_COLOR         = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_tim_t;

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
// ============================================================================
//  Module      : vga_if
//  Description : VGA timing + colour bus linking the stages of the video chain.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/delay_line.sv
// ============================================================================
//  Module      : delay_line
//  Description : DEPTH-stage register pipeline, synchronous reset to zero.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("delay_line: DEPTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/draw_sprite_anim.sv
// ============================================================================
//  Module      : draw_sprite_anim
//  Description : Animated, mirrorable, colour-keyed sprite overlay with
//                per-frame double-buffered position/attributes.
//                Optional: define DRAW_SPRITE_BBOX_EN for a debug border.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module draw_sprite_anim
    import vga_pkg::*;
#(
    parameter int          SPRITE_W  = 130,
    parameter int          SPRITE_H  = 99,
    parameter int          N_FRAMES  = 4,
    parameter int          FRAME_DIV = 8,
    parameter int          ROM_LAT   = 1,
    parameter int          ADDR_W    = 16,
    parameter logic [11:0] KEY_COLOR = SPRITE_KEY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  logic              mirror,
    input  logic              visible,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    vga_if.vga_in             vga_in,
    vga_if.vga_out            vga_out
);

    localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam int FIDX_W   = (N_FRAMES  > 1) ? $clog2(N_FRAMES)  : 1;
    localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int TIM_W    = $bits(vga_tim_t);
`ifdef DRAW_SPRITE_BBOX_EN
    localparam int FLAG_W   = 2;
`else
    localparam int FLAG_W   = 1;
`endif

    generate
        if (longint'(N_FRAMES) * SPRITE_W * SPRITE_H > (longint'(1) << ADDR_W)) begin : g_addr_check
            $error("draw_sprite_anim: ROM image does not fit in ADDR_W bits");
        end
        if (ROM_LAT < 1 || FRAME_DIV < 1) begin : g_param_check
            $error("draw_sprite_anim: ROM_LAT and FRAME_DIV must be >= 1");
        end
    endgenerate

    // Frame boundary detection and per-frame shadow registers
    logic              vblnk_prev_q, vblnk_prev_d;
    logic              fb;
    logic [10:0]       sx_q, sx_d, sy_q, sy_d;
    logic              mirror_s_q, mirror_s_d;
    logic              visible_s_q, visible_s_d;
    logic              anim_en_s_q, anim_en_s_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [FIDX_W-1:0] frame_idx_q, frame_idx_d;

    assign fb = vga_in.vblnk & ~vblnk_prev_q;

    always_comb begin
        vblnk_prev_d = vga_in.vblnk;
        sx_d         = sx_q;
        sy_d         = sy_q;
        mirror_s_d   = mirror_s_q;
        visible_s_d  = visible_s_q;
        anim_en_s_d  = anim_en_s_q;
        if (fb) begin
            sx_d        = pos_x;
            sy_d        = pos_y;
            mirror_s_d  = mirror;
            visible_s_d = visible;
            anim_en_s_d = anim_en;
        end
    end

    // The counter follows the attribute of the frame just ending, and is held
    // at zero while that attribute is off so the idle pose is frame 0.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        frame_idx_d = frame_idx_q;
        if (!anim_en_s_q) begin
            div_cnt_d   = '0;
            frame_idx_d = '0;
        end else if (fb) begin
            if (div_cnt_q == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt_d   = '0;
                frame_idx_d = (frame_idx_q == FIDX_W'(N_FRAMES - 1)) ? '0
                                                                     : frame_idx_q + FIDX_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Stage 1: hit test and ROM address
    logic [11:0]       hc12, vc12, sx12, sy12, rel_x, rx, ry;
    logic              hit_w;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    vga_tim_t          tim1_q, tim1_d;
    logic              hit1_q;

    always_comb begin
        hc12  = {1'b0, vga_in.hcount};
        vc12  = {1'b0, vga_in.vcount};
        sx12  = {1'b0, sx_q};
        sy12  = {1'b0, sy_q};
        hit_w = (hc12 >= sx12) && (hc12 < sx12 + 12'(SPRITE_W)) &&
                (vc12 >= sy12) && (vc12 < sy12 + 12'(SPRITE_H)) &&
                !vga_in.hblnk && !vga_in.vblnk && visible_s_q;
        rel_x = hc12 - sx12;
        rx    = mirror_s_q ? (12'(SPRITE_W - 1) - rel_x) : rel_x;
        ry    = vc12 - sy12;
        rom_addr_d = '0;
        if (hit_w) begin
            rom_addr_d = ADDR_W'(int'(frame_idx_q) * FRAME_SZ) +
                         ADDR_W'(int'(ry) * SPRITE_W) + ADDR_W'(rx);
        end
        tim1_d.hcount = vga_in.hcount;
        tim1_d.vcount = vga_in.vcount;
        tim1_d.hsync  = vga_in.hsync;
        tim1_d.vsync  = vga_in.vsync;
        tim1_d.hblnk  = vga_in.hblnk;
        tim1_d.vblnk  = vga_in.vblnk;
        tim1_d.rgb    = vga_in.rgb;
    end

`ifdef DRAW_SPRITE_BBOX_EN
    logic border_w, border1_q;
    assign border_w = hit_w && (rel_x == 12'd0 || rel_x == 12'(SPRITE_W - 1) ||
                                ry == 12'd0 || ry == 12'(SPRITE_H - 1));
    always_ff @(posedge clk) begin
        if (rst) border1_q <= 1'b0;
        else     border1_q <= border_w;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            mirror_s_q   <= 1'b0;
            visible_s_q  <= 1'b0;
            anim_en_s_q  <= 1'b0;
            div_cnt_q    <= '0;
            frame_idx_q  <= '0;
            rom_addr_q   <= '0;
            tim1_q       <= '0;
            hit1_q       <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            mirror_s_q   <= mirror_s_d;
            visible_s_q  <= visible_s_d;
            anim_en_s_q  <= anim_en_s_d;
            div_cnt_q    <= div_cnt_d;
            frame_idx_q  <= frame_idx_d;
            rom_addr_q   <= rom_addr_d;
            tim1_q       <= tim1_d;
            hit1_q       <= hit_w;
        end
    end

    assign rom_addr = rom_addr_q;

    // Align timing and hit flags with the ROM read data
    logic [TIM_W+FLAG_W-1:0] dl_in, dl_out;
    vga_tim_t                tim_dly;
    logic                    hit_dly;

`ifdef DRAW_SPRITE_BBOX_EN
    logic border_dly;
    assign dl_in = {tim1_q, hit1_q, border1_q};
    assign {tim_dly, hit_dly, border_dly} = dl_out;
`else
    assign dl_in = {tim1_q, hit1_q};
    assign {tim_dly, hit_dly} = dl_out;
`endif

    delay_line #(
        .WIDTH (TIM_W + FLAG_W),
        .DEPTH (ROM_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    // Output stage: colour-keyed merge
    vga_tim_t out_q, out_d;

    always_comb begin
        out_d = tim_dly;
        if (hit_dly && rom_rgb != KEY_COLOR) begin
            out_d.rgb = rom_rgb;
        end
`ifdef DRAW_SPRITE_BBOX_EN
        if (border_dly) begin
            out_d.rgb = BBOX_COLOR;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign vga_out.hcount = out_q.hcount;
    assign vga_out.vcount = out_q.vcount;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.rgb    = out_q.rgb;

endmodule

`default_nettype wire
